// File: rtl/uart_tx_responder.sv
// uart_tx_responder
//   Memory-mapped UART transmitter sitting on the CPU data bus beside the RAM.
//   The CPU pushes bytes into a TX FIFO; an FSM serialises them LSB first on
//   tx_o. Frames are 8N1, or 8E1 when UART_TX_PARITY_EN is defined.
//
//   Register map (addr_i[3:2]):
//     00 DATA   W: push wdata_i[7:0]            R: 0
//     01 STATUS R: [0] busy [1] full [2] empty [3] overflow (sticky, read clears)
//                  [7:4] count (saturating) [8] parity build   W: ignored
//     10 BAUD   R/W [15:0] clk cycles per bit (0 behaves as 1)
//     11 -      R: 0                            W: ignored
//
// Ports
//   clk_i     clock, all logic on posedge
//   resetn_i  asynchronous active-low reset
//   sel_i     address-decode select; access ignored when 0
//   addr_i    byte address; [3:2] select the register
//   rstrb_i   read strobe
//   wstrb_i   write strobe
//   wdata_i   write data
//   wsize_i   access size; irrelevant here since every register uses fixed bits
//   rdata_o   registered read data, updated on a selected read, held otherwise
//   tx_o      serial line, idle high
`timescale 1ns/1ps
module uart_tx_responder #(
   parameter int FIFO_DEPTH      = 8,
   parameter int CLK_DIV_DEFAULT = 16
) (
   input  logic        clk_i,
   input  logic        resetn_i,
   input  logic        sel_i,
   input  logic [13:0] addr_i,
   input  logic        rstrb_i,
   input  logic        wstrb_i,
   input  logic [31:0] wdata_i,
   input  logic [1:0]  wsize_i,
   output logic [31:0] rdata_o,
   output logic        tx_o
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

`ifdef UART_TX_PARITY_EN
   localparam logic PAR_EN = 1'b1;
`else
   localparam logic PAR_EN = 1'b0;
`endif

   // ---------------- bus decode ----------------
   logic [1:0] reg_sel;
   logic       wr_en, rd_en, push_req, push, pop;
   logic       unused_ok;

   assign reg_sel   = addr_i[3:2];
   assign wr_en     = sel_i & wstrb_i;
   assign rd_en     = sel_i & rstrb_i;
   assign push_req  = wr_en & (reg_sel == 2'b00);
   assign unused_ok = ^{wsize_i, addr_i[13:4], addr_i[1:0], wdata_i[31:16]};

   // ---------------- TX FIFO ----------------
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          full, empty;

   assign full  = (count_q == CW'(FIFO_DEPTH));
   assign empty = (count_q == '0);
   assign push  = push_req & ~full;

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset: the pointers define which entries are valid.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= wdata_i[7:0];
   end

   // ---------------- control registers ----------------
   logic [15:0] baud_q;
   logic        ovf_q;

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         baud_q <= 16'(CLK_DIV_DEFAULT);
         ovf_q  <= 1'b0;
      end else begin
         if (wr_en && reg_sel == 2'b10) baud_q <= wdata_i[15:0];
         // A drop on the same edge as a STATUS read must not be lost.
         if (push_req && full)                ovf_q <= 1'b1;
         else if (rd_en && reg_sel == 2'b01)  ovf_q <= 1'b0;
      end
   end

   // ---------------- serialiser FSM ----------------
   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d, div_q, div_d, baud_eff;
   logic [7:0]  shift_q, shift_d;
   logic [2:0]  idx_q, idx_d;
   logic        par_q, par_d, load;

   assign baud_eff = (baud_q == 16'd0) ? 16'd1 : baud_q;

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         div_q   <= 16'd1;
         shift_q <= '0;
         idx_q   <= '0;
         par_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         par_q   <= par_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      shift_d = shift_q;
      idx_d   = idx_q;
      par_d   = par_q;
      load    = 1'b0;
      case (state_q)
         S_IDLE:  load = ~empty;
         S_START: begin
            if (cnt_q == 16'd0) begin
               state_d = S_DATA;
               cnt_d   = div_q - 16'd1;
               idx_d   = 3'd0;
            end else cnt_d = cnt_q - 16'd1;
         end
         S_DATA: begin
            if (cnt_q == 16'd0) begin
               cnt_d = div_q - 16'd1;
               if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  shift_d = shift_q >> 1;
                  idx_d   = idx_q + 3'd1;
               end
            end else cnt_d = cnt_q - 16'd1;
         end
         S_PARITY: begin
            if (cnt_q == 16'd0) begin
               state_d = S_STOP;
               cnt_d   = div_q - 16'd1;
            end else cnt_d = cnt_q - 16'd1;
         end
         S_STOP: begin
            // Chain straight into the next START so queued frames have no gap.
            if (cnt_q == 16'd0) begin
               if (!empty) load = 1'b1;
               else        state_d = S_IDLE;
            end else cnt_d = cnt_q - 16'd1;
         end
         default: state_d = S_IDLE;
      endcase
      // BAUD is sampled only here, so mid-frame writes affect the next frame.
      if (load) begin
         state_d = S_START;
         shift_d = mem_q[rd_ptr_q];
         par_d   = ^mem_q[rd_ptr_q];
         div_d   = baud_eff;
         cnt_d   = baud_eff - 16'd1;
      end
   end

   assign pop = load;

   always_comb begin
      tx_o = 1'b1;
      case (state_q)
         S_START:  tx_o = 1'b0;
         S_DATA:   tx_o = shift_q[0];
         S_PARITY: tx_o = par_q;
         default:  tx_o = 1'b1;
      endcase
   end

   // ---------------- read path ----------------
   logic [3:0]  cnt_sat;
   logic [31:0] status, rdata_d;

   assign cnt_sat = (32'(count_q) > 32'd15) ? 4'hF : 4'(count_q);
   assign status  = {23'd0, PAR_EN, cnt_sat, ovf_q, empty, full, (state_q != S_IDLE)};

   always_comb begin
      rdata_d = 32'd0;
      case (reg_sel)
         2'b01:   rdata_d = status;
         2'b10:   rdata_d = {16'd0, baud_q};
         default: rdata_d = 32'd0;
      endcase
   end

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i)  rdata_o <= 32'd0;
      else if (rd_en) rdata_o <= rdata_d;
   end
endmodule

// File: tb/tb_uart_tx_responder.sv
// Bench for uart_tx_responder. The reference model keeps the FIFO as a byte
// queue and the serial line as a queue of per-cycle expected tx levels built
// frame by frame; tx_o and rdata_o are compared every cycle.
`timescale 1ns/1ps
module tb_uart_tx_responder;
   localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   logic        clk = 1'b0, resetn = 1'b0, sel = 1'b0, rstrb = 1'b0, wstrb = 1'b0;
   logic [13:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [1:0]  wsize = '0;
   logic [31:0] rdata;
   logic        tx;

   uart_tx_responder #(.FIFO_DEPTH(DEPTH), .CLK_DIV_DEFAULT(16)) dut (
      .clk_i(clk), .resetn_i(resetn), .sel_i(sel), .addr_i(addr), .rstrb_i(rstrb),
      .wstrb_i(wstrb), .wdata_i(wdata), .wsize_i(wsize), .rdata_o(rdata), .tx_o(tx));

   always #5 clk = ~clk;

   int tests = 0, fails = 0;

   // reference model state
   bit          rem[$];   // expected tx level for each upcoming cycle
   logic [7:0]  mq[$];    // FIFO contents
   logic [15:0] m_baud;
   bit          m_ovf;
   logic [31:0] exp_rdata;
   bit          exp_tx;

   task automatic model_reset();
      rem.delete(); mq.delete();
      m_baud = 16'd16; m_ovf = 1'b0; exp_rdata = 32'd0; exp_tx = 1'b1;
   endtask

   // One clock edge of the model, given the bus request presented at that edge.
   task automatic model_step(bit s, logic [13:0] a, bit rd, bit wr, logic [31:0] wd);
      logic [1:0] r;
      bit         full_b;
      int         div;
      logic [7:0] b;
      bit         bits[$];
      r = a[3:2];
      full_b = (mq.size() >= DEPTH);
      if (s && rd) begin
         exp_rdata = 32'd0;
         if (r == 2'd1) begin
            exp_rdata[0]   = (rem.size() != 0);
            exp_rdata[1]   = full_b;
            exp_rdata[2]   = (mq.size() == 0);
            exp_rdata[3]   = m_ovf;
            exp_rdata[7:4] = (mq.size() > 15) ? 4'hF : 4'(mq.size());
            exp_rdata[8]   = PAR;
         end else if (r == 2'd2) exp_rdata[15:0] = m_baud;
      end
      if (rem.size() != 0) void'(rem.pop_front());
      if (rem.size() == 0 && mq.size() != 0) begin
         b   = mq.pop_front();
         div = (m_baud == 16'd0) ? 1 : int'(m_baud);
         bits.push_back(1'b0);
         for (int i = 0; i < 8; i++) bits.push_back(b[i]);
         if (PAR) bits.push_back(^b);
         bits.push_back(1'b1);
         foreach (bits[k]) repeat (div) rem.push_back(bits[k]);
      end
      if (s && rd && r == 2'd1) m_ovf = 1'b0;
      if (s && wr) begin
         if (r == 2'd0) begin
            if (full_b) m_ovf = 1'b1;
            else        mq.push_back(wd[7:0]);
         end else if (r == 2'd2) m_baud = wd[15:0];
      end
      exp_tx = (rem.size() != 0) ? rem[0] : 1'b1;
   endtask

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic bus(bit s, logic [13:0] a, bit rd, bit wr, logic [31:0] wd);
      sel = s; addr = a; rstrb = rd; wstrb = wr; wdata = wd;
      wsize = 2'($urandom());
      @(posedge clk);
      model_step(s, a, rd, wr, wd);
      #1;
      check("tx", {31'd0, tx}, {31'd0, exp_tx});
      check("rdata", rdata, exp_rdata);
      sel = 1'b0; rstrb = 1'b0; wstrb = 1'b0;
   endtask

   task automatic idle(int n);
      repeat (n) bus(1'b0, 14'd0, 1'b0, 1'b0, 32'd0);
   endtask

   task automatic wr_reg(logic [1:0] r, logic [31:0] d);
      bus(1'b1, {10'($urandom()), r, 2'($urandom())}, 1'b0, 1'b1, d);
   endtask

   task automatic rd_reg(logic [1:0] r);
      bus(1'b1, {10'($urandom()), r, 2'($urandom())}, 1'b1, 1'b0, 32'd0);
   endtask

   task automatic drain();
      int guard = 0;
      while ((rem.size() != 0 || mq.size() != 0) && guard < 5000) begin
         idle(1);
         guard++;
      end
      check("drain_bound", guard < 5000, 1);
   endtask

   initial begin
      model_reset();
      #23;
      check("rst_tx", {31'd0, tx}, 32'd1);
      check("rst_rdata", rdata, 32'd0);
      @(negedge clk); resetn = 1'b1;
      rd_reg(2'd1);
      check("rst_status", rdata, PAR ? 32'h104 : 32'h004);
      rd_reg(2'd2);
      check("rst_baud", rdata, 32'd16);

      // single frame 0xA5 at BAUD=4
      wr_reg(2'd2, 32'hFFFF_0004);
      wr_reg(2'd0, 32'h1234_56A5);
      drain();
      idle(2);
      rd_reg(2'd1);
      check("a5_idle_busy", {31'd0, rdata[0]}, 32'd0);

      // nine back-to-back bytes at BAUD=2
      wr_reg(2'd2, 32'd2);
      for (int i = 0; i < 9; i++) wr_reg(2'd0, $urandom());
      rd_reg(2'd1);
      check("b2b_no_ovf", {31'd0, rdata[3]}, 32'd0);
      drain();

      // overflow while busy with a full FIFO
      wr_reg(2'd2, 32'd8);
      for (int i = 0; i < 9; i++) wr_reg(2'd0, $urandom());
      wr_reg(2'd0, 32'h33);
      rd_reg(2'd1);
      check("ovf_set", {31'd0, rdata[3]}, 32'd1);
      check("ovf_full", {31'd0, rdata[1]}, 32'd1);
      rd_reg(2'd1);
      check("ovf_clr", {31'd0, rdata[3]}, 32'd0);
      drain();

      // BAUD change mid-frame applies to the next frame only
      wr_reg(2'd2, 32'd2);
      wr_reg(2'd0, 32'h07);
      wr_reg(2'd0, 32'h03);
      idle(5);
      wr_reg(2'd2, 32'd8);
      drain();

      // randomised bus traffic, including divisor 0 and deselected accesses
      for (int n = 0; n < 400; n++) begin
         int op;
         op = $urandom_range(0, 9);
         if (op < 4)       wr_reg(2'd0, $urandom());
         else if (op == 4) wr_reg(2'd2, $urandom_range(0, 3));
         else if (op < 7)  rd_reg(2'($urandom()));
         else if (op == 7) bus(1'b0, 14'($urandom()), 1'($urandom()), 1'($urandom()), $urandom());
         else              idle(1);
      end
      drain();

      // reset during DATA bit 3
      wr_reg(2'd2, 32'd4);
      wr_reg(2'd0, $urandom() & 32'hF7);
      idle(17);
      check("mid_bit3", {31'd0, tx}, 32'd0);
      resetn = 1'b0;
      #1;
      check("mid_rst_tx", {31'd0, tx}, 32'd1);
      model_reset();
      @(negedge clk); resetn = 1'b1;
      rd_reg(2'd1);
      check("mid_rst_status", rdata, PAR ? 32'h104 : 32'h004);
      idle(3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
